// File: rtl/layer_output_serializer.sv
`default_nettype none
// =============================================================================
// layer_output_serializer: gathers per-neuron outputs, then streams them in
// index order. Optional argmax tracking: define ARGMAX_EN.   Revision: 1.0
// =============================================================================
module layer_output_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  output logic                              busy,
  output logic                              layer_done,
  output logic                              ovf,
  output logic [$clog2(NUM_NEURONS)-1:0]    max_idx,
  output logic                              max_valid
);

  localparam int               IDX_W    = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    SHIFT   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_NEURONS-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   buf_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   buf_d [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    hs;

  assign hs = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      buf_d[i] = buf_q[i];
    end

    if (state_q == COLLECT) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (in_valid[i]) begin
          if (!mask_q[i]) begin
            buf_d[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            mask_d[i] = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      if (&mask_d) begin
        state_d = SHIFT;
        idx_d   = '0;
      end
    end else begin
      if (|in_valid) begin
        ovf_d = 1'b1;
      end
      if (hs) begin
        if (idx_q == LAST_IDX) begin
          state_d = COLLECT;
          mask_d  = '0;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end

    // Outputs are registered from next-state so the first word (possibly
    // captured on this very edge) is presented the cycle after the mask fills.
    out_valid_d = (state_d == SHIFT);
    out_last_d  = (state_d == SHIFT) && (idx_d == LAST_IDX);
    out_data_d  = (state_d == SHIFT) ? buf_d[idx_d] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      mask_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      buf_q[i] <= buf_d[i];
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = out_valid_q;
  assign layer_done = done_q;
  assign ovf        = ovf_q;

`ifdef ARGMAX_EN
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_W-1:0]      run_idx_q, run_idx_d;
  logic [IDX_W-1:0]      max_idx_q, max_idx_d;
  logic                  max_valid_q, max_valid_d;
  logic                  gt_max;

  // Strict compare keeps the earlier index on ties.
  assign gt_max = out_data_q > run_max_q;

  always_comb begin
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    max_idx_d   = max_idx_q;
    max_valid_d = 1'b0;
    if (hs) begin
      if ((idx_q == '0) || gt_max) begin
        run_max_d = out_data_q;
        run_idx_d = idx_q;
      end
      if (idx_q == LAST_IDX) begin
        max_idx_d   = gt_max ? idx_q : run_idx_q;
        max_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max_q   <= '0;
      run_idx_q   <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      max_idx_q   <= max_idx_d;
      max_valid_q <= max_valid_d;
    end
  end

  assign max_idx   = max_idx_q;
  assign max_valid = max_valid_q;
`else
  assign max_idx   = '0;
  assign max_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
`default_nettype none
// Directed bench for layer_output_serializer (NUM_NEURONS=4, DATA_WIDTH=8).
module tb_layer_output_serializer;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk       = 1'b0;
  logic           rst       = 1'b0;
  logic [N-1:0]   in_valid  = '0;
  logic [N*W-1:0] in_data   = '0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_last;
  logic           busy;
  logic           layer_done;
  logic           ovf;
  logic [1:0]     max_idx;
  logic           max_valid;

  int check_cnt = 0;
  int err_cnt   = 0;
  int prev_max  = 0;

  always #5 clk = ~clk;

  layer_output_serializer #(
    .NUM_NEURONS(N),
    .DATA_WIDTH (W)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .layer_done(layer_done),
    .ovf       (ovf),
    .max_idx   (max_idx),
    .max_valid (max_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, out_valid, 0);
    check_eq({tag, "_last"},  out_last,  0);
    check_eq({tag, "_busy"},  busy,      0);
    check_eq({tag, "_data"},  out_data,  0);
  endtask

  task automatic pulse(input int n, input logic [W-1:0] v);
    in_data            = {N{8'hEE}};
    in_data[n*W +: W]  = v;
    in_valid           = '0;
    in_valid[n]        = 1'b1;
    tick();
    in_valid = '0;
  endtask

  // Expects to be called with the DUT presenting word `start` and out_ready=1.
  task automatic drain(input logic [N*W-1:0] words, input int start, input int exp_max);
    for (int k = start; k < N; k++) begin
`ifdef ARGMAX_EN
      if (k == start) check_eq("max_idx_hold_pre", max_idx, prev_max);
`endif
      check_eq("out_valid", out_valid, 1);
      check_eq("busy",      busy,      1);
      check_eq("out_data",  out_data,  words[k*W +: W]);
      check_eq("out_last",  out_last,  (k == N-1));
      tick();
    end
    check_eq("layer_done", layer_done, 1);
    check_idle("post_layer");
`ifdef ARGMAX_EN
    check_eq("max_valid", max_valid, 1);
    check_eq("max_idx",   max_idx,   exp_max);
    prev_max = exp_max;
`else
    check_eq("max_valid_off", max_valid, 0);
    check_eq("max_idx_off",   max_idx,   0);
`endif
    tick();
    check_eq("layer_done_pulse", layer_done, 0);
    check_eq("max_valid_pulse",  max_valid,  0);
`ifdef ARGMAX_EN
    check_eq("max_idx_hold", max_idx, prev_max);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check_eq("reset_ovf",       ovf,        0);
    check_eq("reset_done",      layer_done, 0);
    check_eq("reset_max_valid", max_valid,  0);
    check_eq("reset_max_idx",   max_idx,    0);
    rst = 1'b1;

    // All four neurons in one cycle
    in_data  = 32'h40302010;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    drain(32'h40302010, 0, 3);

    // One per cycle in order 2,0,3,1; SHIFT only after the last one
    pulse(2, 8'h90);
    check_idle("order_c2");
    pulse(0, 8'h11);
    check_idle("order_c0");
    pulse(3, 8'h21);
    check_idle("order_c3");
    pulse(1, 8'h05);
    drain(32'h21900511, 0, 2);

    // Backpressure for three cycles at idx 1
    in_data  = 32'h0D0C0B0A;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    check_eq("stall_w0", out_data, 8'h0A);
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data",  out_data,  8'h0B);
      check_eq("stall_last",  out_last,  0);
      tick();
    end
    out_ready = 1'b1;
    drain(32'h0D0C0B0A, 1, 3);

    // Duplicate capture and capture attempt during SHIFT
    check_eq("ovf_clear", ovf, 0);
    pulse(2, 8'h55);
    check_eq("ovf_after_first", ovf, 0);
    pulse(2, 8'h66);
    check_eq("ovf_dup", ovf, 1);
    check_idle("ovf_collect");
    in_data  = 32'h30771020;
    in_valid = 4'b1011;
    tick();
    in_valid = '0;
    check_eq("ovf_w0", out_data, 8'h20);
    in_data  = 32'h00990000;
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    check_eq("ovf_shift", ovf, 1);
    drain(32'h30551020, 1, 2);
    check_eq("ovf_sticky", ovf, 1);

    // Asynchronous reset at idx 2
    in_data  = 32'h04030201;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    check_eq("rst_w0", out_data, 8'h01);
    tick();
    check_eq("rst_w1", out_data, 8'h02);
    tick();
    check_eq("rst_w2", out_data, 8'h03);
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    check_eq("async_rst_ovf",     ovf,     0);
    check_eq("async_rst_max_idx", max_idx, 0);
    prev_max = 0;
    tick();
    rst = 1'b1;
    pulse(0, 8'h05);
    check_idle("restart_c0");
    pulse(1, 8'h06);
    pulse(2, 8'h07);
    check_idle("restart_c2");
    pulse(3, 8'h08);
    drain(32'h08070605, 0, 3);

    // Tie for the maximum: lower index wins
    in_data  = 32'h00107F7F;
    in_valid = 4'hF;
    tick();
    in_valid = '0;
    drain(32'h00107F7F, 0, 0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
